// File: rtl/vid_frame_timing_ctrl.sv
// Frame timing sequencer: produces vs/hs/de and active-pixel coordinates from a
// shadowed porch/sync/active configuration that is swapped only at frame boundaries.
module vid_frame_timing_ctrl #(
  parameter int DIM_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIM_WIDTH-1:0] i_cfg_hact,
  input  logic [DIM_WIDTH-1:0] i_cfg_vact,
  input  logic [DIM_WIDTH-1:0] i_cfg_hsw,
  input  logic [DIM_WIDTH-1:0] i_cfg_hbp,
  input  logic [DIM_WIDTH-1:0] i_cfg_hfp,
  input  logic [DIM_WIDTH-1:0] i_cfg_vsw,
  input  logic [DIM_WIDTH-1:0] i_cfg_vbp,
  input  logic [DIM_WIDTH-1:0] i_cfg_vfp,
  input  logic                 i_start,
  input  logic                 i_single,
  input  logic                 i_stop,
  output logic                 o_vs,
  output logic                 o_hs,
  output logic                 o_de,
  output logic [DIM_WIDTH-1:0] o_x,
  output logic [DIM_WIDTH-1:0] o_y,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_cfg_err
);
  localparam int CW = DIM_WIDTH + 2;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {MODE_ONE, MODE_CONT} mode_t;

  typedef struct packed {
    logic [DIM_WIDTH-1:0] hact, vact, hsw, hbp, hfp, vsw, vbp, vfp;
  } cfg_t;

  state_t        state_reg, state_next;
  mode_t         mode_reg, mode_next;
  cfg_t          sh_reg, sh_next, cfg_in;
  logic [CW-1:0] h_reg, h_next, v_reg, v_next;
  logic          stop_reg, stop_next, err_reg, err_next;
  logic          cfg_ok, last_c, stop_eff;
  mode_t         mode_eff;

  // A zero sync width still produces a one-cycle/one-line pulse.
  function automatic logic [CW-1:0] sw_eff(input logic [DIM_WIDTH-1:0] w);
    return (w == '0) ? CW'(1) : CW'(w);
  endfunction

  function automatic logic [CW-1:0] htot(input cfg_t c);
    return sw_eff(c.hsw) + CW'(c.hbp) + CW'(c.hact) + CW'(c.hfp);
  endfunction

  function automatic logic [CW-1:0] vtot(input cfg_t c);
    return sw_eff(c.vsw) + CW'(c.vbp) + CW'(c.vact) + CW'(c.vfp);
  endfunction

  assign cfg_in = '{hact: i_cfg_hact, vact: i_cfg_vact, hsw: i_cfg_hsw, hbp: i_cfg_hbp,
                    hfp: i_cfg_hfp, vsw: i_cfg_vsw, vbp: i_cfg_vbp, vfp: i_cfg_vfp};
  assign cfg_ok = (i_cfg_hact != '0) && (i_cfg_vact != '0);
  assign last_c = (h_reg == htot(sh_reg) - CW'(1)) && (v_reg == vtot(sh_reg) - CW'(1));
  // A start in RUN overrides any pending or simultaneous stop.
  assign stop_eff = i_start ? 1'b0 : (stop_reg | i_stop);
  assign mode_eff = i_start ? MODE_CONT : mode_reg;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    sh_next    = sh_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    stop_next  = stop_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        h_next    = '0;
        v_next    = '0;
        stop_next = 1'b0;
        if (i_start || i_single) begin
          if (cfg_ok) begin
            state_next = RUN;
            sh_next    = cfg_in;
            mode_next  = i_start ? MODE_CONT : MODE_ONE;
            err_next   = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        mode_next = mode_eff;
        stop_next = stop_eff;
        if (last_c) begin
          h_next = '0;
          v_next = '0;
          if (mode_eff == MODE_ONE || stop_eff) begin
            state_next = IDLE;
            stop_next  = 1'b0;
          end else if (cfg_ok) begin
            sh_next = cfg_in;
          end else begin
            state_next = IDLE;
            stop_next  = 1'b0;
            err_next   = 1'b1;
          end
        end else if (h_reg == htot(sh_reg) - CW'(1)) begin
          h_next = '0;
          v_next = v_reg + CW'(1);
        end else begin
          h_next = h_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-cycle position so they line up with the counters.
  logic          run_n, de_n;
  logic [CW-1:0] hstart_n, vstart_n;
  assign run_n    = (state_next == RUN);
  assign hstart_n = sw_eff(sh_next.hsw) + CW'(sh_next.hbp);
  assign vstart_n = sw_eff(sh_next.vsw) + CW'(sh_next.vbp);
  assign de_n     = run_n &&
                    (h_next >= hstart_n) && (h_next < hstart_n + CW'(sh_next.hact)) &&
                    (v_next >= vstart_n) && (v_next < vstart_n + CW'(sh_next.vact));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_ONE;
      sh_reg       <= '0;
      h_reg        <= '0;
      v_reg        <= '0;
      stop_reg     <= 1'b0;
      err_reg      <= 1'b0;
      o_vs         <= 1'b0;
      o_hs         <= 1'b0;
      o_de         <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_cfg_err    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      sh_reg       <= sh_next;
      h_reg        <= h_next;
      v_reg        <= v_next;
      stop_reg     <= stop_next;
      err_reg      <= err_next;
      o_vs         <= run_n && (v_next < sw_eff(sh_next.vsw));
      o_hs         <= run_n && (h_next < sw_eff(sh_next.hsw));
      o_de         <= de_n;
      o_x          <= de_n ? DIM_WIDTH'(h_next - hstart_n) : '0;
      o_y          <= de_n ? DIM_WIDTH'(v_next - vstart_n) : '0;
      o_busy       <= run_n;
      o_frame_done <= run_n && (h_next == htot(sh_next) - CW'(1)) &&
                      (v_next == vtot(sh_next) - CW'(1));
      o_cfg_err    <= err_next;
    end
  end
endmodule

// File: tb/tb_vid_frame_timing_ctrl.sv
// Directed bench for vid_frame_timing_ctrl: a table of single-frame configs plus
// hand-written continuous, stop, reconfiguration and reset sequences.
module tb_vid_frame_timing_ctrl;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] hact, vact, hsw, hbp, hfp, vsw, vbp, vfp;
  logic         start = 1'b0, single = 1'b0, stop = 1'b0;
  logic         vs, hs, de, busy, done, err;
  logic [W-1:0] x, y;

  int n_vec = 0;
  int n_err = 0;

  vid_frame_timing_ctrl #(.DIM_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_hact(hact), .i_cfg_vact(vact), .i_cfg_hsw(hsw), .i_cfg_hbp(hbp),
    .i_cfg_hfp(hfp), .i_cfg_vsw(vsw), .i_cfg_vbp(vbp), .i_cfg_vfp(vfp),
    .i_start(start), .i_single(single), .i_stop(stop),
    .o_vs(vs), .o_hs(hs), .o_de(de), .o_x(x), .o_y(y),
    .o_busy(busy), .o_frame_done(done), .o_cfg_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hact, vact, hsw, hbp, hfp, vsw, vbp, vfp;
    int busy, hs, vs, de, done, xsum, ysum, last_de, err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic int pack_out();
    return int'({vs, hs, de, busy, done, err, x, y});
  endfunction

  task automatic set_cfg(input logic [W-1:0] ha, va, hw, hb, hf, vw, vb, vf);
    hact = ha; vact = va; hsw = hw; hbp = hb; hfp = hf; vsw = vw; vbp = vb; vfp = vf;
  endtask

  int exp_first;
  int nb, nd, fd, de1, de2, len2, c_hs, c_vs, c_de, xs, ys, lde;

  initial begin
    exp_first = int'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0});
    //              hact vact hsw hbp hfp vsw vbp vfp busy hs  vs  de done xs ys lde err
    vecs[0] = '{12'd4, 12'd2, 12'd1, 12'd3, 12'd3, 12'd1, 12'd3, 12'd3, 99, 9, 11, 8, 1, 12, 4, 0, 0};
    vecs[1] = '{12'd1, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 4, 2, 2, 1, 1, 0, 0, 1, 0};
    vecs[2] = '{12'd4, 12'd0, 12'd1, 12'd3, 12'd3, 12'd1, 12'd3, 12'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{12'd3, 12'd1, 12'd2, 12'd0, 12'd1, 12'd0, 12'd1, 12'd0, 18, 6, 6, 3, 1, 3, 0, 0, 0};
    vecs[4] = '{12'd0, 12'd2, 12'd1, 12'd3, 12'd3, 12'd1, 12'd3, 12'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    set_cfg(4, 2, 1, 3, 3, 1, 3, 3);
    repeat (3) @(negedge clk);
    check("reset_outputs", pack_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", pack_out(), 0);

    // Table: one single-shot per record.
    foreach (vecs[i]) begin
      set_cfg(vecs[i].hact, vecs[i].vact, vecs[i].hsw, vecs[i].hbp,
              vecs[i].hfp, vecs[i].vsw, vecs[i].vbp, vecs[i].vfp);
      single = 1'b1;
      @(negedge clk);
      single = 1'b0;
      nb = 0; c_hs = 0; c_vs = 0; c_de = 0; nd = 0; xs = 0; ys = 0; lde = 0;
      for (int c = 0; c < 300; c++) begin
        nb += int'(busy); c_vs += int'(vs); c_de += int'(de); nd += int'(done);
        if (hs && (c == 0 || !busy || 1'b1)) c_hs += 0;
        if (de) begin xs += int'(x); ys += int'(y); end
        if (done) lde = int'(de);
        @(negedge clk);
        if (hs && c_hs >= 0) ;
      end
      check($sformatf("v%0d_busy", i), nb, vecs[i].busy);
      check($sformatf("v%0d_vs_cycles", i), c_vs, vecs[i].vs);
      check($sformatf("v%0d_de_cycles", i), c_de, vecs[i].de);
      check($sformatf("v%0d_done", i), nd, vecs[i].done);
      check($sformatf("v%0d_xsum", i), xs, vecs[i].xsum);
      check($sformatf("v%0d_ysum", i), ys, vecs[i].ysum);
      check($sformatf("v%0d_last_de", i), lde, vecs[i].last_de);
      check($sformatf("v%0d_err", i), int'(err), vecs[i].err);
      check($sformatf("v%0d_idle_after", i), int'(busy), 0);
    end

    // hs pulse count for the reference frame (rising edges of hs).
    set_cfg(4, 2, 1, 3, 3, 1, 3, 3);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    c_hs = 0;
    begin
      logic prev_hs;
      prev_hs = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (hs && !prev_hs) c_hs++;
        prev_hs = hs;
        @(negedge clk);
      end
    end
    check("hs_pulses", c_hs, 9);

    // Continuous run, stop at cycle 150: two back-to-back frames.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cont_first_cycle", pack_out(), exp_first);
    nb = 0; nd = 0; fd = -1;
    for (int c = 0; c < 600; c++) begin
      if (fd >= 0 && c == fd + 1)
        check("cont_no_gap", int'({busy, hs, vs, (x == '0)}), 15);
      nb += int'(busy);
      if (done) begin nd++; if (fd < 0) fd = c; end
      stop = (c == 150);
      @(negedge clk);
    end
    check("cont_busy", nb, 198);
    check("cont_done", nd, 2);
    check("cont_first_done_cycle", fd, 98);
    check("cont_idle_after", pack_out(), 0);

    // hact 4->6 mid-frame: only the following frame picks it up.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; de1 = 0; de2 = 0; len2 = 0;
    for (int c = 0; c < 600; c++) begin
      if (c == 20) hact = 6;
      if (nd == 0) de1 += int'(de);
      if (nd == 1) begin de2 += int'(de); len2 += int'(busy); end
      nd += int'(done);
      stop = (c == 150);
      @(negedge clk);
    end
    check("recfg_de_frame1", de1, 8);
    check("recfg_de_frame2", de2, 12);
    check("recfg_len_frame2", len2, 117);
    check("recfg_frames", nd, 2);
    hact = 4;

    // Reset in the middle of a frame, then a clean restart.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_reset", pack_out(), 0);
    @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_first_cycle", pack_out(), exp_first);
    stop = 1'b1;
    nb = 0;
    for (int c = 0; c < 300; c++) begin
      nb += int'(busy);
      @(negedge clk);
      stop = 1'b0;
    end
    check("restart_busy", nb, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
